note_envelope_ctrl: RTL and testbench
=====================================

Name: note_envelope_ctrl

Overview:
- Responder to the CPU-side note command interface (global synth reset, note start, note release, note finished, note reset).
- Consumes single-cycle command strobes from the memory-mapped register block.
- Runs an ADSR state machine that produces a 12-bit amplitude envelope, one update per sample tick.
- Drives the phase accumulator reset and reports note completion back for CPU polling.

Parameters:
- ENV_WIDTH, 12, width of envelope output and all step/level inputs.
- ENV_MAX, 4095, full-scale envelope value; must equal 2^ENV_WIDTH-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- note_start  input  1  one-cycle strobe: begin or retrigger note
- note_release  input  1  one-cycle strobe: key released
- note_reset  input  1  one-cycle strobe: abort note and return to idle (also driven by global synth reset)
- sample_tick  input  1  one-cycle strobe at sample rate; envelope advances only on this
- attack_step  input  ENV_WIDTH  increment per tick in ATTACK
- decay_step  input  ENV_WIDTH  decrement per tick in DECAY
- sustain_level  input  ENV_WIDTH  hold level in SUSTAIN
- release_step  input  ENV_WIDTH  decrement per tick in RELEASE
- envelope  output  ENV_WIDTH  registered envelope amplitude
- note_active  output  1  high in ATTACK, DECAY, SUSTAIN, RELEASE
- note_finished  output  1  high in FINISHED; CPU-readable status
- accum_reset  output  1  registered; high in IDLE and FINISHED, holds phase accumulator at 0
- state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, FINISHED=5

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, envelope=0, note_finished=0, note_active=0, accum_reset=1.
- All outputs are registered. Commands take effect on the clk edge where they are sampled; outputs reflect it the next cycle.
- Command priority, same cycle: note_reset > note_start > note_release > sample_tick. A tick coincident with any command that is acted on is dropped.
- note_reset, any state: go to IDLE, envelope=0, note_finished=0.
- note_start, any state: go to ATTACK, note_finished=0. Envelope is not cleared, so a retrigger ramps from the current value (no click). From IDLE/FINISHED the envelope is already 0.
- note_release:
  - In ATTACK, DECAY or SUSTAIN: go to RELEASE; envelope holds its current value.
  - In IDLE, RELEASE or FINISHED: ignored.
- ATTACK, on tick:
  - sum = envelope + attack_step, computed ENV_WIDTH+1 bits wide.
  - If sum >= ENV_MAX: envelope=ENV_MAX and go to DECAY on the same edge. Otherwise envelope=sum.
  - attack_step=0 is treated as instantaneous: envelope=ENV_MAX, go to DECAY.
- DECAY, on tick:
  - diff = envelope - decay_step, signed ENV_WIDTH+1 bits.
  - If diff <= sustain_level: envelope=sustain_level and go to SUSTAIN. Otherwise envelope=diff.
  - decay_step=0: envelope=sustain_level, go to SUSTAIN.
  - If sustain_level >= envelope on entry: first tick goes directly to SUSTAIN.
- SUSTAIN:
  - envelope follows sustain_level every cycle, without waiting for a tick, so CPU edits take effect immediately.
  - Stays until note_release, note_start or note_reset.
- RELEASE, on tick:
  - diff = envelope - release_step, signed.
  - If diff <= 0: envelope=0 and go to FINISHED. Otherwise envelope=diff.
  - release_step=0: envelope=0, go to FINISHED.
- FINISHED:
  - envelope=0, note_finished=1.
  - Held until note_reset (to IDLE) or note_start (to ATTACK).
- IDLE: ticks ignored, envelope=0.
- accum_reset and note_active are decoded from the next state and registered, so they change on the same edge as state.
- No wrap-around is possible: all arithmetic saturates at 0 and ENV_MAX.
- rst asserted mid-note forces IDLE immediately (asynchronously); the first edge after deassertion is normal operation.

Test Plan:
- Reset mid-ATTACK (envelope=300): assert rst -> state=0, envelope=0, accum_reset=1, note_finished=0 immediately, without waiting for a clk edge.
- Full ADSR, attack_step=1000, decay_step=500, sustain_level=2000, release_step=700, ticks every 4 cycles, note_start:
  - Envelope 1000, 2000, 3000, 4000, 4095 (enters DECAY on that tick).
  - Then 3595, 3095, 2595, 2095, 2000 (enters SUSTAIN).
  - note_release -> 1300, 600, 0 -> FINISHED, note_finished=1, accum_reset=1.
- Priority: note_reset, note_start and sample_tick asserted in the same cycle while in SUSTAIN -> state=IDLE, envelope=0. note_start+note_release together from IDLE -> ATTACK.
- Retrigger in RELEASE at envelope=1500, attack_step=1000: note_start -> ATTACK, next tick envelope=2500, note_finished stays 0.
- Zero steps, all steps=0, sustain_level=800: note_start, tick -> 4095/DECAY, tick -> 800/SUSTAIN. Change sustain_level to 1200 -> envelope=1200 next cycle with no tick. note_release, tick -> 0/FINISHED.
- Ignored commands: note_release in IDLE and in FINISHED -> no state change. Ticks in IDLE -> envelope stays 0.

Source files
------------

// File: rtl/note_envelope_ctrl.sv
// note_envelope_ctrl: ADSR envelope generator driven by single-cycle CPU
// command strobes. The envelope advances once per sample tick. In SUSTAIN it
// tracks sustain_level every cycle. Every output is registered.
module note_envelope_ctrl #(
  parameter int          ENV_WIDTH = 12,
  parameter int unsigned ENV_MAX   = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 note_start,
  input  logic                 note_release,
  input  logic                 note_reset,
  input  logic                 sample_tick,
  input  logic [ENV_WIDTH-1:0] attack_step,
  input  logic [ENV_WIDTH-1:0] decay_step,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_step,
  output logic [ENV_WIDTH-1:0] envelope,
  output logic                 note_active,
  output logic                 note_finished,
  output logic                 accum_reset,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ATTACK   = 3'd1,
    ST_DECAY    = 3'd2,
    ST_SUSTAIN  = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_FINISHED = 3'd5
  } env_state_t;

  localparam logic [ENV_WIDTH-1:0] MAX_V   = ENV_WIDTH'(ENV_MAX);
  localparam logic [ENV_WIDTH:0]   MAX_W   = (ENV_WIDTH+1)'(ENV_MAX);
  localparam logic [ENV_WIDTH-1:0] ZERO_V  = {ENV_WIDTH{1'b0}};
  localparam logic [ENV_WIDTH:0]   ZERO_W  = {(ENV_WIDTH+1){1'b0}};

  env_state_t           state_r;
  env_state_t           state_nxt_s;
  logic [ENV_WIDTH-1:0] envelope_r;
  logic [ENV_WIDTH-1:0] envelope_nxt_s;
  logic                 note_active_r;
  logic                 note_finished_r;
  logic                 accum_reset_r;

  // One extra bit keeps the attack sum and the decay/release differences
  // free of wrap-around, so saturation is decided on the true value.
  logic        [ENV_WIDTH:0] attack_sum_s;
  logic signed [ENV_WIDTH:0] decay_diff_s;
  logic signed [ENV_WIDTH:0] release_diff_s;
  logic signed [ENV_WIDTH:0] sustain_w_s;

  assign attack_sum_s   = {1'b0, envelope_r} + {1'b0, attack_step};
  assign decay_diff_s   = $signed({1'b0, envelope_r}) - $signed({1'b0, decay_step});
  assign release_diff_s = $signed({1'b0, envelope_r}) - $signed({1'b0, release_step});
  assign sustain_w_s    = $signed({1'b0, sustain_level});

  // Next-state and next-envelope decode with command priority reset > start > release > tick.
  always_comb begin
    state_nxt_s    = state_r;
    envelope_nxt_s = envelope_r;
    if (note_reset) begin
      state_nxt_s    = ST_IDLE;
      envelope_nxt_s = ZERO_V;
    end else if (note_start) begin
      // Retrigger ramps from the current level to avoid an audible click.
      state_nxt_s    = ST_ATTACK;
      envelope_nxt_s = envelope_r;
    end else if (note_release &&
                 ((state_r == ST_ATTACK) || (state_r == ST_DECAY) || (state_r == ST_SUSTAIN))) begin
      state_nxt_s    = ST_RELEASE;
      envelope_nxt_s = envelope_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          envelope_nxt_s = ZERO_V;
        end
        ST_ATTACK: begin
          if (sample_tick) begin
            if ((attack_step == ZERO_V) || (attack_sum_s >= MAX_W)) begin
              envelope_nxt_s = MAX_V;
              state_nxt_s    = ST_DECAY;
            end else begin
              envelope_nxt_s = attack_sum_s[ENV_WIDTH-1:0];
            end
          end else begin
            envelope_nxt_s = envelope_r;
          end
        end
        ST_DECAY: begin
          if (sample_tick) begin
            if ((decay_step == ZERO_V) || (decay_diff_s <= sustain_w_s)) begin
              envelope_nxt_s = sustain_level;
              state_nxt_s    = ST_SUSTAIN;
            end else begin
              envelope_nxt_s = decay_diff_s[ENV_WIDTH-1:0];
            end
          end else begin
            envelope_nxt_s = envelope_r;
          end
        end
        ST_SUSTAIN: begin
          // Follows the register every cycle so CPU edits are heard at once.
          envelope_nxt_s = sustain_level;
        end
        ST_RELEASE: begin
          if (sample_tick) begin
            if ((release_step == ZERO_V) || (release_diff_s <= $signed(ZERO_W))) begin
              envelope_nxt_s = ZERO_V;
              state_nxt_s    = ST_FINISHED;
            end else begin
              envelope_nxt_s = release_diff_s[ENV_WIDTH-1:0];
            end
          end else begin
            envelope_nxt_s = envelope_r;
          end
        end
        ST_FINISHED: begin
          envelope_nxt_s = ZERO_V;
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          envelope_nxt_s = ZERO_V;
        end
      endcase
    end
  end

  // State, envelope and status flags; flags decode the next state so they move with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      envelope_r      <= ZERO_V;
      note_active_r   <= 1'b0;
      note_finished_r <= 1'b0;
      accum_reset_r   <= 1'b1;
    end else begin
      state_r         <= state_nxt_s;
      envelope_r      <= envelope_nxt_s;
      note_active_r   <= (state_nxt_s == ST_ATTACK) || (state_nxt_s == ST_DECAY) ||
                         (state_nxt_s == ST_SUSTAIN) || (state_nxt_s == ST_RELEASE);
      note_finished_r <= (state_nxt_s == ST_FINISHED);
      accum_reset_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FINISHED);
    end
  end

  assign envelope      = envelope_r;
  assign note_active   = note_active_r;
  assign note_finished = note_finished_r;
  assign accum_reset   = accum_reset_r;
  assign state         = state_r;

endmodule

// File: tb/tb_note_envelope_ctrl.sv
// Directed testbench for note_envelope_ctrl with hand-computed expectations.
module tb_note_envelope_ctrl;

  logic        clk;
  logic        rst;
  logic        note_start;
  logic        note_release;
  logic        note_reset;
  logic        sample_tick;
  logic [11:0] attack_step;
  logic [11:0] decay_step;
  logic [11:0] sustain_level;
  logic [11:0] release_step;
  logic [11:0] envelope;
  logic        note_active;
  logic        note_finished;
  logic        accum_reset;
  logic [2:0]  state;

  int pass_cnt = 0;
  int total_cnt = 0;

  note_envelope_ctrl dut (
    .clk(clk), .rst(rst),
    .note_start(note_start), .note_release(note_release),
    .note_reset(note_reset), .sample_tick(sample_tick),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .envelope(envelope), .note_active(note_active),
    .note_finished(note_finished), .accum_reset(accum_reset),
    .state(state)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
  endtask

  task automatic do_start();
    note_start = 1'b1; step(); note_start = 1'b0;
  endtask

  task automatic do_release();
    note_release = 1'b1; step(); note_release = 1'b0;
  endtask

  task automatic do_nreset();
    note_reset = 1'b1; step(); note_reset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total_cnt++;
    if ({state, envelope, note_active, note_finished, accum_reset} !== {3'd0, 12'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got st=%0d env=%0d act=%b fin=%b ar=%b, want 0 0 0 0 1",
               state, envelope, note_active, note_finished, accum_reset);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({state, envelope, accum_reset} !== {3'd0, 12'd0, 1'b1})
      $display("FAIL post_reset_idle: got st=%0d env=%0d ar=%b, want 0 0 1", state, envelope, accum_reset);
    else pass_cnt++;
  endtask

  task automatic test_full_adsr();
    logic [11:0] exp_env [10] = '{12'd1000, 12'd2000, 12'd3000, 12'd4000, 12'd4095,
                                  12'd3595, 12'd3095, 12'd2595, 12'd2095, 12'd2000};
    logic [2:0]  exp_st  [10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [11:0] rel_env [3]  = '{12'd1300, 12'd600, 12'd0};
    logic [2:0]  rel_st  [3]  = '{3'd4, 3'd4, 3'd5};
    attack_step = 12'd1000; decay_step = 12'd500; sustain_level = 12'd2000; release_step = 12'd700;
    do_start();
    total_cnt++;
    if ({state, envelope, note_active, accum_reset} !== {3'd1, 12'd0, 1'b1, 1'b0})
      $display("FAIL adsr_start: got st=%0d env=%0d act=%b ar=%b, want 1 0 1 0", state, envelope, note_active, accum_reset);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({state, envelope} !== {exp_st[i], exp_env[i]})
        $display("FAIL adsr_tick%0d: got st=%0d env=%0d, want st=%0d env=%0d", i, state, envelope, exp_st[i], exp_env[i]);
      else pass_cnt++;
      step(); step(); step();
    end
    do_release();
    total_cnt++;
    if ({state, envelope} !== {3'd4, 12'd2000})
      $display("FAIL adsr_release_entry: got st=%0d env=%0d, want 4 2000", state, envelope);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({state, envelope} !== {rel_st[i], rel_env[i]})
        $display("FAIL adsr_rel%0d: got st=%0d env=%0d, want st=%0d env=%0d", i, state, envelope, rel_st[i], rel_env[i]);
      else pass_cnt++;
      step(); step(); step();
    end
    total_cnt++;
    if ({note_finished, accum_reset, note_active} !== {1'b1, 1'b1, 1'b0})
      $display("FAIL adsr_finished_flags: got fin=%b ar=%b act=%b, want 1 1 0", note_finished, accum_reset, note_active);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    attack_step = 12'd0; decay_step = 12'd0; sustain_level = 12'd2000;
    do_start(); tick(); tick();
    total_cnt++;
    if ({state, envelope} !== {3'd3, 12'd2000})
      $display("FAIL prio_setup_sustain: got st=%0d env=%0d, want 3 2000", state, envelope);
    else pass_cnt++;
    note_reset = 1'b1; note_start = 1'b1; sample_tick = 1'b1;
    step();
    note_reset = 1'b0; note_start = 1'b0; sample_tick = 1'b0;
    total_cnt++;
    if ({state, envelope, accum_reset} !== {3'd0, 12'd0, 1'b1})
      $display("FAIL prio_reset_wins: got st=%0d env=%0d ar=%b, want 0 0 1", state, envelope, accum_reset);
    else pass_cnt++;
    note_start = 1'b1; note_release = 1'b1;
    step();
    note_start = 1'b0; note_release = 1'b0;
    total_cnt++;
    if ({state, note_active} !== {3'd1, 1'b1})
      $display("FAIL prio_start_over_release: got st=%0d act=%b, want 1 1", state, note_active);
    else pass_cnt++;
    do_nreset();
  endtask

  task automatic test_retrigger();
    attack_step = 12'd0; decay_step = 12'd0; sustain_level = 12'd1500;
    do_start(); tick(); tick(); do_release();
    total_cnt++;
    if ({state, envelope} !== {3'd4, 12'd1500})
      $display("FAIL retrig_setup: got st=%0d env=%0d, want 4 1500", state, envelope);
    else pass_cnt++;
    attack_step = 12'd1000;
    do_start();
    total_cnt++;
    if ({state, envelope, note_finished} !== {3'd1, 12'd1500, 1'b0})
      $display("FAIL retrig_attack: got st=%0d env=%0d fin=%b, want 1 1500 0", state, envelope, note_finished);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, envelope, note_finished} !== {3'd1, 12'd2500, 1'b0})
      $display("FAIL retrig_ramp: got st=%0d env=%0d fin=%b, want 1 2500 0", state, envelope, note_finished);
    else pass_cnt++;
    do_nreset();
  endtask

  task automatic test_zero_steps();
    attack_step = 12'd0; decay_step = 12'd0; sustain_level = 12'd800; release_step = 12'd0;
    do_start(); tick();
    total_cnt++;
    if ({state, envelope} !== {3'd2, 12'd4095})
      $display("FAIL zero_attack: got st=%0d env=%0d, want 2 4095", state, envelope);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, envelope} !== {3'd3, 12'd800})
      $display("FAIL zero_decay: got st=%0d env=%0d, want 3 800", state, envelope);
    else pass_cnt++;
    sustain_level = 12'd1200;
    step();
    total_cnt++;
    if ({state, envelope} !== {3'd3, 12'd1200})
      $display("FAIL sustain_follow: got st=%0d env=%0d, want 3 1200", state, envelope);
    else pass_cnt++;
    do_release(); tick();
    total_cnt++;
    if ({state, envelope, note_finished} !== {3'd5, 12'd0, 1'b1})
      $display("FAIL zero_release: got st=%0d env=%0d fin=%b, want 5 0 1", state, envelope, note_finished);
    else pass_cnt++;
  endtask

  task automatic test_ignored();
    do_release();
    total_cnt++;
    if ({state, note_finished} !== {3'd5, 1'b1})
      $display("FAIL ign_release_finished: got st=%0d fin=%b, want 5 1", state, note_finished);
    else pass_cnt++;
    do_nreset();
    total_cnt++;
    if ({state, note_finished, accum_reset} !== {3'd0, 1'b0, 1'b1})
      $display("FAIL finished_to_idle: got st=%0d fin=%b ar=%b, want 0 0 1", state, note_finished, accum_reset);
    else pass_cnt++;
    do_release(); tick(); tick(); tick();
    total_cnt++;
    if ({state, envelope} !== {3'd0, 12'd0})
      $display("FAIL ign_idle: got st=%0d env=%0d, want 0 0", state, envelope);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_attack();
    attack_step = 12'd300;
    do_start(); tick();
    total_cnt++;
    if ({state, envelope} !== {3'd1, 12'd300})
      $display("FAIL midatk_setup: got st=%0d env=%0d, want 1 300", state, envelope);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({state, envelope, accum_reset, note_finished} !== {3'd0, 12'd0, 1'b1, 1'b0})
      $display("FAIL async_reset: got st=%0d env=%0d ar=%b fin=%b, want 0 0 1 0",
               state, envelope, accum_reset, note_finished);
    else pass_cnt++;
    step();
    rst = 1'b0;
    do_start();
    total_cnt++;
    if ({state, envelope} !== {3'd1, 12'd0})
      $display("FAIL after_reset_start: got st=%0d env=%0d, want 1 0", state, envelope);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; note_start = 1'b0; note_release = 1'b0; note_reset = 1'b0; sample_tick = 1'b0;
    attack_step = 12'd0; decay_step = 12'd0; sustain_level = 12'd0; release_step = 12'd0;
    test_reset();
    test_full_adsr();
    test_ignored();
    test_priority();
    test_retrigger();
    test_zero_steps();
    do_nreset();
    test_reset_mid_attack();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
